result_dumper: RTL and testbench
================================

RESULT_DUMPER -- requirements
Module: result_dumper

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data-memory word and address width; a multiple of 8.
REQ-002 SHALL have parameter BASE_ADDR, default 16'd1023: first data-memory address dumped.
REQ-003 SHALL have parameter WORD_COUNT, default 1024: number of words dumped; 0 is legal.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port proc_state  input  1  all-cores-finished flag from the processor top.
REQ-007 SHALL have port mem_addr  output  WIDTH  data-memory read address.
REQ-008 SHALL have port mem_rEn  output  1  data-memory read enable.
REQ-009 SHALL have port mem_data  input  WIDTH  data-memory read data, valid exactly 1 cycle after mem_rEn.
REQ-010 SHALL have port tx_data  output  8  outgoing byte.
REQ-011 SHALL have port tx_valid  output  1  tx_data valid.
REQ-012 SHALL have port tx_ready  input  1  sink accepts the byte in any cycle where tx_valid && tx_ready.
REQ-013 SHALL have port busy  output  1  dump in progress.
REQ-014 SHALL have port done  output  1  dump complete; sticky.

Function
REQ-015 SHALL use the FSM states IDLE, READ, WAIT, SEND, NEXT, TAIL and FIN.
REQ-016 SHALL start a dump only on a rising edge of proc_state, detected with a registered copy of proc_state; a high level at reset release SHALL NOT start a dump.
REQ-017 SHALL, on the start edge in IDLE or FIN, clear done, set busy, load addr=BASE_ADDR and cnt=0, and move to READ, or to TAIL if WORD_COUNT==0.
REQ-018 SHALL, in READ, drive mem_rEn=1 with mem_addr=addr for exactly one cycle, then move to WAIT.
REQ-019 SHALL, in WAIT, capture mem_data into a WIDTH-bit shift register and move to SEND; first byte tx_valid SHALL occur 2 cycles after mem_rEn.
REQ-020 SHALL, in SEND, present WIDTH/8 bytes MSB-first.
REQ-021 SHALL hold tx_data stable and tx_valid high until the byte is accepted; tx_valid SHALL NOT drop without acceptance.
REQ-022 SHALL advance one byte per accepted handshake, so back-to-back acceptance gives one byte per cycle.
REQ-023 SHALL, after the last byte of a word is accepted, go to NEXT: addr+1 modulo 2^WIDTH (wraps 16'hFFFF->16'h0000), cnt+1; then READ if cnt<WORD_COUNT, else TAIL.
REQ-024 SHALL, in TAIL, behave per REQ-033/034, then go to FIN: busy=0, done=1.
REQ-025 SHALL ignore proc_state falling or toggling during a dump; a rising edge while busy SHALL be ignored and SHALL NOT be queued.
REQ-026 SHALL keep mem_rEn=0 in every state except READ; mem_addr SHALL hold its last value otherwise.

Reset
REQ-027 SHALL, on rst=1 at a clock edge (including mid-dump), force state=IDLE, tx_valid=0, tx_data=0, mem_rEn=0, mem_addr=0, busy=0, done=0, proc_state history=0, checksum=0.
REQ-028 SHALL discard any byte presented when reset hits; no partial word SHALL be resumed.

Configuration
REQ-029 SHALL use the macro RESULT_DUMPER_CHECKSUM_EN.
REQ-030 SHALL, when the macro is defined, keep an 8-bit XOR of every accepted data byte, cleared at dump start.
REQ-031 SHALL, when the macro is defined, send that checksum as one extra byte in TAIL under the REQ-021 handshake.
REQ-032 SHALL, when the macro is undefined, have no checksum logic.
REQ-033 SHALL, when the macro is undefined, make TAIL pass to FIN in one cycle with tx_valid=0.
REQ-034 SHALL, when the macro is defined and WORD_COUNT==0, send only checksum byte 8'h00.

Structure
REQ-035 SHALL take the FSM state enum, the core MEMID base constants (1023, 1535, 1791, 1279, 1407, 1919, 1663, 1151) and the default BASE_ADDR/WORD_COUNT from the shared package proc_pkg.
REQ-036 SHALL place the load/shift/byte-count/handshake logic in one sub-module, dump_serializer, which raises a last-byte-accepted pulse to the FSM.

Verification
REQ-037 SHALL cover: WORD_COUNT=2, mem[1023]=16'hA1B2, mem[1024]=16'hC3D4, tx_ready=1, proc_state 0->1 -> bytes A1,B2,C3,D4 on consecutive accepts, mem_rEn pulses at 1023 and 1024, done=1, busy=0; with the macro defined, a fifth byte 8'h00.
REQ-038 SHALL cover: same data, tx_ready low for 5 cycles on byte 2 -> tx_valid stays 1 and tx_data=8'hB2 stable throughout, with no mem_rEn during the stall.
REQ-039 SHALL cover: BASE_ADDR=16'hFFFF, WORD_COUNT=2 -> reads at 16'hFFFF then 16'h0000.
REQ-040 SHALL cover: rst=1 after byte 3 of a 4-word dump -> next cycle tx_valid=0, busy=0, done=0; a fresh rising edge restarts at BASE_ADDR.
REQ-041 SHALL cover: proc_state high at reset release -> no dump; proc_state pulsed 0->1->0->1 mid-dump -> exactly one dump occurs.
REQ-042 SHALL cover: WORD_COUNT=0 -> done within 3 cycles of the edge, with no mem_rEn and no bytes (macro off) or one byte 8'h00 (macro on).

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor-side definitions: dump FSM states, core MEMID bases and
// the default dump window used by result_dumper.
package proc_pkg;

   // Dump sequencer states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      WAIT = 3'd2,
      SEND = 3'd3,
      NEXT = 3'd4,
      TAIL = 3'd5,
      FIN  = 3'd6
   } dump_state_t;

   // Per-core MEMID base addresses in data memory
   localparam int unsigned MEMID_CORE0 = 1023;
   localparam int unsigned MEMID_CORE1 = 1535;
   localparam int unsigned MEMID_CORE2 = 1791;
   localparam int unsigned MEMID_CORE3 = 1279;
   localparam int unsigned MEMID_CORE4 = 1407;
   localparam int unsigned MEMID_CORE5 = 1919;
   localparam int unsigned MEMID_CORE6 = 1663;
   localparam int unsigned MEMID_CORE7 = 1151;

   // Default dump window: starts at core 0's results
   localparam int unsigned DEFAULT_BASE_ADDR  = MEMID_CORE0;
   localparam int unsigned DEFAULT_WORD_COUNT = 1024;

   // True while the sequencer owns the memory port or the byte stream
   function automatic logic state_is_busy(input dump_state_t s);
      return (s == READ) || (s == WAIT) || (s == SEND) || (s == NEXT) || (s == TAIL);
   endfunction

endpackage

// File: rtl/dump_serializer.sv
// Word-to-byte serializer: loads a WIDTH-bit word (or a single byte held in
// the top lane) and presents it MSB-first under a valid/ready handshake.
// last_accept_c pulses in the cycle the final byte of the load is accepted.
module dump_serializer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             load_single,
   input  logic [WIDTH-1:0] load_data,
   input  logic             tx_ready,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   output logic             last_accept_c
);

   localparam int unsigned NBYTES = WIDTH / 8;
   localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] remain;
   logic             accept_c;

   assign accept_c      = tx_valid & tx_ready;
   assign last_accept_c = accept_c & (remain == '0);

   // Load, then shift one byte out per accepted handshake; hold while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         shreg    <= '0;
         remain   <= '0;
      end else if (load) begin
         tx_valid <= 1'b1;
         tx_data  <= load_data[WIDTH-1 -: 8];
         shreg    <= load_data << 8;
         remain   <= load_single ? '0 : CNT_W'(NBYTES - 1);
      end else if (accept_c) begin
         if (remain == '0) begin
            tx_valid <= 1'b0;
         end else begin
            tx_data <= shreg[WIDTH-1 -: 8];
            shreg   <= shreg << 8;
            remain  <= remain - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/result_dumper.sv
// Result dumper: on a rising edge of the processor's all-finished flag,
// reads WORD_COUNT words from data memory starting at BASE_ADDR and streams
// them out MSB-first as bytes.
// Optional feature macro RESULT_DUMPER_CHECKSUM_EN appends an XOR checksum
// byte of all data bytes after the last word.
module result_dumper
   import proc_pkg::*;
#(
   parameter int unsigned      WIDTH      = 16,
   parameter logic [WIDTH-1:0] BASE_ADDR  = WIDTH'(DEFAULT_BASE_ADDR),
   parameter int unsigned      WORD_COUNT = DEFAULT_WORD_COUNT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             proc_state,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_rEn,
   input  logic [WIDTH-1:0] mem_data,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic             done
);

   dump_state_t      state, state_nxt;
   logic [WIDTH-1:0] addr, addr_nxt;
   logic [31:0]      cnt, cnt_nxt;
   logic             ps_q;
   logic             armed;
   logic             start_c;
   logic             ser_load_c;
   logic             ser_single_c;
   logic [WIDTH-1:0] ser_word_c;
   logic             last_accept_c;

`ifdef RESULT_DUMPER_CHECKSUM_EN
   logic [7:0]       csum;
   logic [WIDTH-1:0] tail_word_c;
`endif

   // A start needs a fresh 0->1 edge seen after reset; a level held high
   // through reset release never looks like an edge because armed lags a cycle.
   assign start_c = proc_state & ~ps_q & armed & ((state == IDLE) || (state == FIN));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, address/count update and serializer load control
   always_comb begin
      state_nxt    = state;
      addr_nxt     = addr;
      cnt_nxt      = cnt;
      ser_load_c   = 1'b0;
      ser_single_c = 1'b0;
      ser_word_c   = mem_data;
      case (state)
         IDLE, FIN: begin
            if (start_c) begin
               addr_nxt  = BASE_ADDR;
               cnt_nxt   = 32'd0;
               state_nxt = (WORD_COUNT == 0) ? TAIL : READ;
            end
         end
         READ: state_nxt = WAIT;
         WAIT: begin
            ser_load_c = 1'b1;
            state_nxt  = SEND;
         end
         SEND: begin
            if (last_accept_c) state_nxt = NEXT;
         end
         NEXT: begin
            addr_nxt  = addr + WIDTH'(1);
            cnt_nxt   = cnt + 32'd1;
            state_nxt = (cnt_nxt < WORD_COUNT) ? READ : TAIL;
         end
`ifdef RESULT_DUMPER_CHECKSUM_EN
         TAIL: begin
            if (last_accept_c) state_nxt = FIN;
         end
`else
         TAIL: state_nxt = FIN;
`endif
         default: state_nxt = IDLE;
      endcase
`ifdef RESULT_DUMPER_CHECKSUM_EN
      // Checksum byte is loaded on entry to TAIL; an empty dump sends zero
      tail_word_c = '0;
      tail_word_c[WIDTH-1 -: 8] = (state == NEXT) ? csum : 8'h00;
      if ((state_nxt == TAIL) && (state != TAIL)) begin
         ser_load_c   = 1'b1;
         ser_single_c = 1'b1;
         ser_word_c   = tail_word_c;
      end
`endif
   end

   // Datapath registers and registered status / memory-port outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         addr     <= '0;
         cnt      <= 32'd0;
         ps_q     <= 1'b0;
         armed    <= 1'b0;
         mem_addr <= '0;
         mem_rEn  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         addr    <= addr_nxt;
         cnt     <= cnt_nxt;
         ps_q    <= proc_state;
         armed   <= 1'b1;
         mem_rEn <= (state_nxt == READ);
         if (state_nxt == READ) mem_addr <= addr_nxt;
         busy    <= state_is_busy(state_nxt);
         done    <= (state_nxt == FIN);
      end
   end

`ifdef RESULT_DUMPER_CHECKSUM_EN
   // Running XOR of data bytes accepted during SEND, cleared on each start
   always_ff @(posedge clk) begin
      if (rst) begin
         csum <= 8'h00;
      end else if (start_c) begin
         csum <= 8'h00;
      end else if ((state == SEND) && tx_valid && tx_ready) begin
         csum <= csum ^ tx_data;
      end
   end
`endif

   dump_serializer #(
      .WIDTH (WIDTH)
   ) u_serializer (
      .clk           (clk),
      .rst           (rst),
      .load          (ser_load_c),
      .load_single   (ser_single_c),
      .load_data     (ser_word_c),
      .tx_ready      (tx_ready),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .last_accept_c (last_accept_c)
   );

endmodule

// File: tb/tb_result_dumper.sv
// Testbench for result_dumper: four instances with different dump windows
// share one clock, reset and data memory. Expected byte streams and read
// addresses come from a word-list model of the dump window.
// Honours RESULT_DUMPER_CHECKSUM_EN when defined for the build.
module tb_result_dumper;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  ps = 4'b0000;
   logic [3:0]  ready = 4'b1111;
   logic [15:0] maddr [4];
   logic [15:0] mdata [4];
   logic [7:0]  tdata [4];
   logic [3:0]  ren, valid, busy, done;
   logic [15:0] mem [0:65535];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Monitor records
   logic [7:0]  got   [4][64];
   int          got_t [4][64];
   int          got_n [4] = '{default: 0};
   logic [15:0] rd    [4][64];
   int          rd_t  [4][64];
   int          rd_n  [4] = '{default: 0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam logic [15:0] B  = (g == 1) ? 16'hFFFF : 16'd1023;
      localparam int unsigned WC = (g == 2) ? 0 : ((g == 3) ? 4 : 2);
      result_dumper #(.WIDTH(16), .BASE_ADDR(B), .WORD_COUNT(WC)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .proc_state (ps[g]),
         .mem_addr   (maddr[g]),
         .mem_rEn    (ren[g]),
         .mem_data   (mdata[g]),
         .tx_data    (tdata[g]),
         .tx_valid   (valid[g]),
         .tx_ready   (ready[g]),
         .busy       (busy[g]),
         .done       (done[g])
      );
      always @(posedge clk) if (ren[g]) mdata[g] <= mem[maddr[g]];
   end

   // Log accepted bytes and read strobes
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (valid[i] && ready[i] && got_n[i] < 64) begin
            got[i][got_n[i]]   = tdata[i];
            got_t[i][got_n[i]] = cyc;
            got_n[i]++;
         end
         if (ren[i] && rd_n[i] < 64) begin
            rd[i][rd_n[i]]   = maddr[i];
            rd_t[i][rd_n[i]] = cyc;
            rd_n[i]++;
         end
      end
   end

   function automatic logic [15:0] base_of(input int i);
      return (i == 1) ? 16'hFFFF : 16'd1023;
   endfunction

   function automatic int wc_of(input int i);
      return (i == 2) ? 0 : ((i == 3) ? 4 : 2);
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Run one dump on instance i and compare against the word-list model
   task automatic do_dump(input int i, input bit rnd_ready, input bit fill,
                          output int gb, output int ab);
      logic [7:0]  exp_b[$];
      logic [15:0] exp_a[$];
      logic [7:0]  cs;
      logic [15:0] a, w;
      int n;
      cs = 8'h00;
      for (int k = 0; k < wc_of(i); k++) begin
         a = 16'(base_of(i) + 16'(k));
         if (fill) mem[a] = 16'($urandom);
         w = mem[a];
         exp_a.push_back(a);
         exp_b.push_back(w[15:8]);
         exp_b.push_back(w[7:0]);
         cs = cs ^ w[15:8] ^ w[7:0];
      end
`ifdef RESULT_DUMPER_CHECKSUM_EN
      exp_b.push_back(cs);
`endif
      gb = got_n[i];
      ab = rd_n[i];
      @(posedge clk); #1;
      ps[i] = 1'b1;
      ready[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy[i] !== 1'b1 || done[i] !== 1'b0) begin
         errors++;
         $display("FAIL start_status[%0d]: busy=%b done=%b, expected busy=1 done=0", i, busy[i], done[i]);
      end
      for (n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         ready[i] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (done[i]) break;
      end
      @(posedge clk); #1;
      ps[i] = 1'b0;
      ready[i] = 1'b1;
      checks++;
      if (n >= 400) begin
         errors++;
         $display("FAIL dump_timeout[%0d]: done never rose, expected done=1", i);
      end
      @(negedge clk);
      checks++;
      if (busy[i] !== 1'b0 || done[i] !== 1'b1 || valid[i] !== 1'b0) begin
         errors++;
         $display("FAIL end_status[%0d]: busy=%b done=%b valid=%b, expected 0 1 0", i, busy[i], done[i], valid[i]);
      end
      checks++;
      if (got_n[i] - gb != exp_b.size()) begin
         errors++;
         $display("FAIL byte_count[%0d]: got %0d, expected %0d", i, got_n[i] - gb, exp_b.size());
      end
      for (int k = 0; k < exp_b.size() && gb + k < got_n[i]; k++) begin
         checks++;
         if (got[i][gb + k] !== exp_b[k]) begin
            errors++;
            $display("FAIL byte[%0d][%0d]: got %02h, expected %02h", i, k, got[i][gb + k], exp_b[k]);
         end
      end
      checks++;
      if (rd_n[i] - ab != exp_a.size()) begin
         errors++;
         $display("FAIL read_count[%0d]: got %0d, expected %0d", i, rd_n[i] - ab, exp_a.size());
      end
      for (int k = 0; k < exp_a.size() && ab + k < rd_n[i]; k++) begin
         checks++;
         if (rd[i][ab + k] !== exp_a[k]) begin
            errors++;
            $display("FAIL read_addr[%0d][%0d]: got %04h, expected %04h", i, k, rd[i][ab + k], exp_a[k]);
         end
      end
   endtask

   // Reset values, and a level held high through reset release starts nothing
   task automatic test_reset();
      int gb, ab;
      rst = 1'b1;
      ps[0] = 1'b1;
      idle(3);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (valid[i] !== 1'b0 || tdata[i] !== 8'h00 || ren[i] !== 1'b0 ||
             maddr[i] !== 16'h0000 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_values[%0d]: valid=%b data=%02h ren=%b addr=%04h busy=%b done=%b, expected all 0",
                     i, valid[i], tdata[i], ren[i], maddr[i], busy[i], done[i]);
         end
      end
      gb = got_n[0];
      ab = rd_n[0];
      @(posedge clk); #1;
      rst = 1'b0;
      idle(10);
      @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0 || rd_n[0] != ab || got_n[0] != gb) begin
         errors++;
         $display("FAIL level_no_start: busy=%b reads=%0d bytes=%0d, expected 0 0 0", busy[0], rd_n[0] - ab, got_n[0] - gb);
      end
      @(posedge clk); #1;
      ps[0] = 1'b0;
      idle(2);
   endtask

   // Fixed two-word dump: byte order, read latency and back-to-back bytes
   task automatic test_basic();
      int gb, ab;
      mem[16'd1023] = 16'hA1B2;
      mem[16'd1024] = 16'hC3D4;
      do_dump(0, 1'b0, 1'b0, gb, ab);
      checks++;
      if (got_t[0][gb] - rd_t[0][ab] != 2) begin
         errors++;
         $display("FAIL first_byte_latency: got %0d cycles, expected 2", got_t[0][gb] - rd_t[0][ab]);
      end
      checks++;
      if (got_t[0][gb + 1] - got_t[0][gb] != 1 || got_t[0][gb + 3] - got_t[0][gb + 2] != 1) begin
         errors++;
         $display("FAIL back_to_back: byte gaps %0d %0d, expected 1 1",
                  got_t[0][gb + 1] - got_t[0][gb], got_t[0][gb + 3] - got_t[0][gb + 2]);
      end
      idle(2);
   endtask

   // Sink stalls for 5 cycles on byte 2: data held, no memory reads
   task automatic test_stall();
      int gb, n;
      mem[16'd1023] = 16'hA1B2;
      mem[16'd1024] = 16'hC3D4;
      gb = got_n[0];
      ready[0] = 1'b1;
      ps[0] = 1'b1;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (valid[0] && tdata[0] == 8'hA1) break;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL stall_first_byte: A1 never presented, expected A1");
      end
      @(posedge clk); #1;
      ready[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (valid[0] !== 1'b1 || tdata[0] !== 8'hB2 || ren[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: valid=%b data=%02h ren=%b, expected 1 B2 0", k, valid[0], tdata[0], ren[0]);
         end
      end
      @(posedge clk); #1;
      ready[0] = 1'b1;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (done[0]) break;
      end
      @(posedge clk); #1;
      ps[0] = 1'b0;
      checks++;
      if (got_n[0] - gb < 4 || got[0][gb] !== 8'hA1 || got[0][gb + 1] !== 8'hB2 ||
          got[0][gb + 2] !== 8'hC3 || got[0][gb + 3] !== 8'hD4) begin
         errors++;
         $display("FAIL stall_stream: got %0d bytes %02h %02h %02h %02h, expected A1 B2 C3 D4",
                  got_n[0] - gb, got[0][gb], got[0][gb + 1], got[0][gb + 2], got[0][gb + 3]);
      end
      idle(2);
   endtask

   // Address wrap from FFFF to 0000
   task automatic test_wrap();
      int gb, ab;
      do_dump(1, 1'b1, 1'b1, gb, ab);
      idle(2);
   endtask

   // Reset after byte 3 of a 4-word dump, then a clean restart
   task automatic test_reset_mid();
      int gb, ab, n;
      gb = got_n[3];
      ready[3] = 1'b1;
      ps[3] = 1'b1;
      for (n = 0; n < 100; n++) begin
         @(posedge clk); #1;
         if (got_n[3] - gb >= 3) break;
      end
      rst = 1'b1;
      ready[3] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (valid[3] !== 1'b0 || busy[3] !== 1'b0 || done[3] !== 1'b0 || ren[3] !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: valid=%b busy=%b done=%b ren=%b, expected all 0", valid[3], busy[3], done[3], ren[3]);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      ps[3] = 1'b0;
      ready[3] = 1'b1;
      idle(3);
      do_dump(3, 1'b1, 1'b1, gb, ab);
      idle(2);
   endtask

   // Toggling proc_state mid-dump produces exactly one dump
   task automatic test_toggle();
      int gb, ab, n, exp_n;
      exp_n = 4;
`ifdef RESULT_DUMPER_CHECKSUM_EN
      exp_n = 5;
`endif
      gb = got_n[0];
      ab = rd_n[0];
      mem[16'd1023] = 16'($urandom);
      mem[16'd1024] = 16'($urandom);
      ps[0] = 1'b1;
      idle(4);
      ps[0] = 1'b0;
      idle(1);
      ps[0] = 1'b1;
      idle(2);
      ps[0] = 1'b0;
      idle(1);
      ps[0] = 1'b1;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (done[0]) break;
      end
      idle(30);
      @(negedge clk);
      checks++;
      if (got_n[0] - gb != exp_n || rd_n[0] - ab != 2 || busy[0] !== 1'b0 || done[0] !== 1'b1) begin
         errors++;
         $display("FAIL single_dump: bytes=%0d reads=%0d busy=%b done=%b, expected %0d 2 0 1",
                  got_n[0] - gb, rd_n[0] - ab, busy[0], done[0], exp_n);
      end
      @(posedge clk); #1;
      ps[0] = 1'b0;
      idle(2);
   endtask

   // Empty dump: quick completion, no reads, checksum-only stream if enabled
   task automatic test_zero();
      int gb, ab, n, exp_n;
      exp_n = 0;
`ifdef RESULT_DUMPER_CHECKSUM_EN
      exp_n = 1;
`endif
      gb = got_n[2];
      ab = rd_n[2];
      ready[2] = 1'b1;
      ps[2] = 1'b1;
      for (n = 1; n <= 5; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (done[2]) break;
      end
      checks++;
      if (n > 3) begin
         errors++;
         $display("FAIL zero_latency: done after %0d cycles, expected at most 3", n);
      end
      idle(3);
      checks++;
      if (rd_n[2] != ab || got_n[2] - gb != exp_n) begin
         errors++;
         $display("FAIL zero_stream: reads=%0d bytes=%0d, expected 0 %0d", rd_n[2] - ab, got_n[2] - gb, exp_n);
      end
      if (exp_n == 1 && got_n[2] > gb) begin
         checks++;
         if (got[2][gb] !== 8'h00) begin
            errors++;
            $display("FAIL zero_checksum: got %02h, expected 00", got[2][gb]);
         end
      end
      ps[2] = 1'b0;
      idle(2);
   endtask

   // Randomized repeat dumps, restarting from the finished state
   task automatic test_random();
      int gb, ab;
      for (int r = 0; r < 3; r++) begin
         do_dump(0, 1'b1, 1'b1, gb, ab);
         do_dump(3, 1'b1, 1'b1, gb, ab);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_reset_mid();
      test_toggle();
      test_zero();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
